apb_master_bridge: RTL and testbench

APB requester that converts a simple valid/ready command channel into APB3 SETUP/ACCESS transfers and returns read data and error status on a valid/ready response channel. It sits directly upstream of the APB slave memory block on the same `clk`. It is the only driver of `paddr`, `pwrite`, `psel`, `penable` and `pwdata`. One transfer is in flight at a time, with a one-entry response holding register.

---
 rtl/apb_pkg.sv | 9 +
 rtl/apb_master_rsp_reg.sv | 22 ++
 rtl/apb_master_bridge.sv | 93 +++++++++
 tb/tb_apb_master_bridge.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types for the APB requester bridge (FSM states, response entry).
package apb_pkg;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} apb_master_state_t;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;
endpackage

// File: rtl/apb_master_rsp_reg.sv
// apb_master_rsp_reg: one-entry response holding register with valid/ready.
module apb_master_rsp_reg
  import apb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  apb_rsp_t rsp_d,
  input  logic     rsp_ready,
  output logic     rsp_valid,
  output apb_rsp_t rsp_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      rsp_valid <= load || (rsp_valid && !rsp_ready);
      if (load) rsp_q <= rsp_d;
    end
  end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command channel to APB3 SETUP/ACCESS transfers with response channel.
// Define APB_MASTER_LATE_RDATA_EN to sample read data/pslverr one cycle after the completing ACCESS.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int addrWidth      = 32,
  parameter int dataWidth      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic                 cmd_write,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready,
  input  logic                 pslverr
);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  apb_master_state_t state;
  logic [TW-1:0] to_cnt;
  logic timeout, done;
  apb_rsp_t rsp_d, rsp_q;
  assign cmd_ready = !rst && state == IDLE && (!rsp_valid || rsp_ready);
  assign timeout = TIMEOUT_CYCLES != 0 && state == ACCESS && !pready && to_cnt == TW'(TIMEOUT_CYCLES - 1);
`ifdef APB_MASTER_LATE_RDATA_EN
  assign done = timeout || (state == ACCESS && pready && pwrite) || state == RDWAIT;
`else
  assign done = timeout || (state == ACCESS && pready);
`endif
  always_comb begin
    rsp_d.err   = timeout || pslverr;
    rsp_d.rdata = (timeout || pwrite) ? '0 : APB_DATA_W'(prdata);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      to_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          state  <= SETUP;
          psel   <= 1'b1;
          paddr  <= cmd_addr;
          pwrite <= cmd_write;
          pwdata <= cmd_wdata;
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
          to_cnt  <= '0;
        end
        ACCESS: if (pready || timeout) begin
          psel    <= 1'b0;
          penable <= 1'b0;
`ifdef APB_MASTER_LATE_RDATA_EN
          state   <= (pready && !pwrite) ? RDWAIT : IDLE;
`else
          state   <= IDLE;
`endif
        end else to_cnt <= to_cnt + TW'(1);
        default: state <= IDLE;
      endcase
    end
  end
  apb_master_rsp_reg u_rsp (
    .clk      (clk),
    .rst      (rst),
    .load     (done),
    .rsp_d    (rsp_d),
    .rsp_ready(rsp_ready),
    .rsp_valid(rsp_valid),
    .rsp_q    (rsp_q)
  );
  assign rsp_rdata = rsp_q.rdata[dataWidth-1:0];
  assign rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB requester bridge against a small APB completer model.
module tb_apb_master_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic pwrite, psel, penable, pready, pslverr;
  logic [31:0] mem [0:15];
  int stall_n = 0, acc_cnt;
  logic err_flag = 1'b0;
  logic ps [0:63];
  logic pe [0:63];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  apb_master_bridge dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  assign pready  = psel && penable && (acc_cnt >= stall_n);
  assign pslverr = err_flag;
  always_ff @(posedge clk) begin
    if (rst || !(psel && penable)) acc_cnt <= 0;
    else if (!pready) acc_cnt <= acc_cnt + 1;
    if (rst) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (psel && penable && pready && pwrite) mem[paddr[5:2]] <= pwdata;
  end
`ifdef APB_MASTER_LATE_RDATA_EN
  localparam int rd_lat = 4;
  always_ff @(posedge clk) if (psel && penable && pready && !pwrite) prdata <= mem[paddr[5:2]];
`else
  localparam int rd_lat = 3;
  assign prdata = mem[paddr[5:2]];
`endif

  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d;
    #1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); #1; k++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 63) begin ps[k] = psel; pe[k] = penable; @(negedge clk); k++; end
    ps[k] = psel; pe[k] = penable;
    lat = rsp_valid ? k : -1;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (psel !== 1'b0) begin failures++; $display("FAIL reset_psel got=%b exp=0", psel); end
    checks++; if (penable !== 1'b0) begin failures++; $display("FAIL reset_penable got=%b exp=0", penable); end
    checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin failures++; $display("FAIL reset_apb got=%h/%h/%b exp=0/0/0", paddr, pwdata, pwrite); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write;
    int lat; logic [31:0] rd; logic er;
    run_xfer(32'h10, 1'b1, 32'hDEADBEEF, lat, rd, er);
    checks++; if (lat !== 3) begin failures++; $display("FAIL write_latency got=%0d exp=3", lat); end
    checks++; if (ps[1] !== 1'b1 || pe[1] !== 1'b0) begin failures++; $display("FAIL write_setup got=%b%b exp=10", ps[1], pe[1]); end
    checks++; if (ps[2] !== 1'b1 || pe[2] !== 1'b1) begin failures++; $display("FAIL write_access got=%b%b exp=11", ps[2], pe[2]); end
    checks++; if (ps[3] !== 1'b0 || pe[3] !== 1'b0) begin failures++; $display("FAIL write_done_idle got=%b%b exp=00", ps[3], pe[3]); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL write_rsp got=%b/%h exp=0/00000000", er, rd); end
    checks++; if (paddr !== 32'h10 || pwrite !== 1'b1 || pwdata !== 32'hDEADBEEF) begin failures++; $display("FAIL write_hold got=%h/%b/%h exp=10/1/deadbeef", paddr, pwrite, pwdata); end
  endtask

  task automatic test_read;
    int lat; logic [31:0] rd; logic er;
    run_xfer(32'h10, 1'b0, 32'h0, lat, rd, er);
    checks++; if (lat !== rd_lat) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", lat, rd_lat); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL read_data got=%h/%b exp=deadbeef/0", rd, er); end
    checks++; if (ps[2] !== 1'b1 || pe[2] !== 1'b1 || ps[3] !== 1'b0) begin failures++; $display("FAIL read_phases got=%b%b%b exp=110", ps[2], pe[2], ps[3]); end
  endtask

  task automatic test_wait_err;
    int lat; logic [31:0] rd; logic er;
    stall_n = 5; err_flag = 1'b1;
    run_xfer(32'h18, 1'b1, 32'h0BADF00D, lat, rd, er);
    checks++; if (lat !== 8) begin failures++; $display("FAIL wait_latency got=%0d exp=8", lat); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL wait_err got=%b/%h exp=1/00000000", er, rd); end
    checks++; if (ps[7] !== 1'b1 || pe[7] !== 1'b1) begin failures++; $display("FAIL wait_last_access got=%b%b exp=11", ps[7], pe[7]); end
    stall_n = 0; err_flag = 1'b0;
  endtask

  task automatic test_timeout;
    int lat; logic [31:0] rd; logic er;
    stall_n = 1000;
    run_xfer(32'h10, 1'b0, 32'h0, lat, rd, er);
    checks++; if (lat !== 18) begin failures++; $display("FAIL timeout_latency got=%0d exp=18", lat); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL timeout_rsp got=%b/%h exp=1/00000000", er, rd); end
    checks++; if (ps[17] !== 1'b1 || pe[17] !== 1'b1 || ps[18] !== 1'b0 || pe[18] !== 1'b0) begin failures++; $display("FAIL timeout_abort got=%b%b%b%b exp=1100", ps[17], pe[17], ps[18], pe[18]); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL timeout_idle got=%b exp=1", cmd_ready); end
    stall_n = 0;
  endtask

  task automatic test_back_to_back;
    int k; logic bad;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_write = 1'b1; cmd_wdata = 32'h12345678;
    @(negedge clk);
    cmd_addr = 32'h20; cmd_write = 1'b0; cmd_wdata = 32'h0;
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_first_rsp got=%b exp=1", rsp_valid); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL bp_stall got=%b exp=0", bad); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (psel !== 1'b1 || penable !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_second_setup got=%b%b%b exp=100", psel, penable, rsp_valid); end
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL bp_second_rsp got=%b/%h exp=1/12345678", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    stall_n = 1000;
    cmd_valid = 1'b1; cmd_addr = 32'h14; cmd_write = 1'b1; cmd_wdata = 32'h11111111;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (penable !== 1'b1) begin failures++; $display("FAIL rstmid_access got=%b exp=1", penable); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_clear got=%b%b%b exp=000", psel, penable, rsp_valid); end
    rst = 1'b0; stall_n = 0;
    run_xfer(32'h14, 1'b1, 32'hCAFEF00D, lat, rd, er);
    checks++; if (lat !== 3 || er !== 1'b0) begin failures++; $display("FAIL rstmid_write got=%0d/%b exp=3/0", lat, er); end
    run_xfer(32'h14, 1'b0, 32'h0, lat, rd, er);
    checks++; if (lat !== rd_lat || rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rstmid_read got=%0d/%h exp=%0d/cafef00d", lat, rd, rd_lat); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
